// File: rtl/crc_pkg.sv
// Shared CRC-16 constants and checker state encoding, common to the serial
// encoder and checker.
package crc_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DATA   = 2'b01,
    CHECK  = 2'b10,
    REPORT = 2'b11
  } state_t;

endpackage

// File: rtl/crc16_serial_checker_if.sv
// Serial-line side (start/bit stream) and frame-consumer side (payload, result)
// of the CRC-16 checker, bundled as one interface.
interface crc16_serial_checker_if #(
  parameter int LEN_W = 12
) ();

  logic             start;
  logic             bit_valid;
  logic             bit_in;
  logic             last_data;
  logic             data_out;
  logic             data_valid;
  logic             busy;
  logic             done;
  logic             crc_ok;
  logic             crc_err;
  logic [15:0]      rx_crc;
  logic [LEN_W-1:0] bit_count;

  modport master (
    output start, bit_valid, bit_in, last_data,
    input  data_out, data_valid, busy, done, crc_ok, crc_err, rx_crc, bit_count
  );

  modport slave (
    input  start, bit_valid, bit_in, last_data,
    output data_out, data_valid, busy, done, crc_ok, crc_err, rx_crc, bit_count
  );

endinterface

// File: rtl/crc16_lfsr_step.sv
// One bit of a non-augmented CRC-16 LFSR (MSB first). Purely combinational so
// the serial encoder can reuse it unchanged.
module crc16_lfsr_step
  import crc_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY
) (
  input  logic [15:0] lfsr,
  input  logic        bit_in,
  output logic [15:0] lfsr_next
);

  logic fb;

  assign fb        = lfsr[15] ^ bit_in;
  assign lfsr_next = {lfsr[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);

endmodule

// File: rtl/crc16_serial_checker.sv
// Receive-side serial CRC-16 checker: forwards payload bits, absorbs the
// trailing 16 CRC bits and reports whether the whole codeword checks out.
module crc16_serial_checker
  import crc_pkg::*;
#(
  parameter logic [15:0] POLY  = CRC16_POLY,
  parameter logic [15:0] INIT  = CRC16_INIT,
  parameter int          LEN_W = 12
) (
  input logic                   clk,
  input logic                   rst,
  crc16_serial_checker_if.slave bus
);

  state_t           state, state_next;
  logic [15:0]      lfsr, lfsr_next;
  logic [LEN_W-1:0] bit_count;
  logic             ovf;
  logic [4:0]       crc_cnt;
  logic [15:0]      rx_crc;
  logic             data_out, data_valid;
  logic             crc_ok, crc_err;
  logic             accept, crc_last, result_ok;

  // start wins over any bit presented on the same cycle.
  assign accept    = bus.bit_valid & ~bus.start & ((state == DATA) | (state == CHECK));
  assign crc_last  = accept & (state == CHECK) & (crc_cnt == 5'd15);
  assign result_ok = (lfsr_next == 16'h0000) & ~ovf;

  crc16_lfsr_step #(.POLY(POLY)) u_step (
    .lfsr      (lfsr),
    .bit_in    (bus.bit_in),
    .lfsr_next (lfsr_next)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: state_next is defaulted first so no path through the case leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = IDLE;
      DATA:    if (accept && bus.last_data) state_next = CHECK;
      CHECK:   if (crc_last) state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.start) state_next = DATA;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr       <= INIT;
      bit_count  <= '0;
      ovf        <= 1'b0;
      crc_cnt    <= '0;
      rx_crc     <= '0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      crc_ok     <= 1'b0;
      crc_err    <= 1'b0;
    end else if (bus.start) begin
      lfsr       <= INIT;
      bit_count  <= '0;
      ovf        <= 1'b0;
      crc_cnt    <= '0;
      rx_crc     <= '0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      crc_ok     <= 1'b0;
      crc_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (accept) lfsr <= lfsr_next;
      if (accept && (state == DATA)) begin
        data_out   <= bus.bit_in;
        data_valid <= 1'b1;
        // Saturate rather than wrap; a too-long frame can never pass.
        if (&bit_count) ovf <= 1'b1;
        else            bit_count <= bit_count + 1'b1;
      end
      if (accept && (state == CHECK)) begin
        rx_crc  <= {rx_crc[14:0], bus.bit_in};
        crc_cnt <= crc_cnt + 5'd1;
      end
      // Result is latched on the final CRC edge so it is valid alongside done.
      if (crc_last) begin
        crc_ok  <= result_ok;
        crc_err <= ~result_ok;
      end
    end
  end

  assign bus.data_out   = data_out;
  assign bus.data_valid = data_valid;
  assign bus.busy       = (state == DATA) | (state == CHECK);
  assign bus.done       = (state == REPORT);
  assign bus.crc_ok     = crc_ok;
  assign bus.crc_err    = crc_err;
  assign bus.rx_crc     = rx_crc;
  assign bus.bit_count  = bit_count;

endmodule

// File: tb/tb_crc16_serial_checker.sv
// Directed bench for crc16_serial_checker: known-good and corrupted frames,
// bit gaps, abort by start, async reset and bit-counter overflow.
module tb_crc16_serial_checker;
  import crc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  crc16_serial_checker_if #(.LEN_W(12)) bus ();
  crc16_serial_checker_if #(.LEN_W(4))  bus4 ();

  crc16_serial_checker #(.LEN_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  crc16_serial_checker #(.LEN_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor of the 12-bit instance: payload stream and done pulses.
  int          dv_count   = 0;
  int          done_count = 0;
  logic [71:0] rx_bits    = '0;

  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      if (dv_count < 72) rx_bits[71-dv_count] = bus.data_out;
      dv_count++;
    end
    if (bus.done === 1'b1) done_count++;
  end

  logic [71:0] msg;

  task automatic clear_mon();
    dv_count   = 0;
    done_count = 0;
    rx_bits    = '0;
  endtask

  // Start pulse with a junk bit (valid, last) that must be ignored.
  task automatic do_start();
    bus.start     = 1'b1;
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    bus.last_data = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.last_data = 1'b0;
  endtask

  task automatic drive_bit(input logic b, input logic last, input int gap_pct);
    int g = 0;
    while (g < 3 && $urandom_range(0, 99) < gap_pct) begin
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'($urandom_range(0, 1));
      bus.last_data = 1'($urandom_range(0, 1));
      @(negedge clk);
      g++;
    end
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    bus.last_data = last;
    @(negedge clk);
    bus.bit_valid = 1'b0;
    bus.last_data = 1'b0;
  endtask

  // Returns done as seen one cycle after the edge that took the last bit.
  task automatic drive_frame(input logic [71:0] pay, input int n, input logic [15:0] crc,
                             input int ncrc, input int gap_pct, output logic done_lat);
    do_start();
    for (int i = 0; i < n; i++) drive_bit(pay[71-i], (i == n - 1), gap_pct);
    for (int i = 0; i < ncrc; i++) drive_bit(crc[15-i], 1'b0, gap_pct);
    done_lat = bus.done;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0; bus.last_data = 1'b0;
    bus4.start = 1'b0; bus4.bit_valid = 1'b0; bus4.bit_in = 1'b0; bus4.last_data = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.data_valid, bus.data_out, bus.done, bus.crc_ok, bus.crc_err,
         bus.rx_crc, bus.bit_count} !== 34'd0)
      $display("FAIL reset_outputs: got busy=%b dv=%b done=%b ok=%b err=%b rx_crc=%h cnt=%0d, want all 0",
               bus.busy, bus.data_valid, bus.done, bus.crc_ok, bus.crc_err, bus.rx_crc, bus.bit_count);
    else n_pass++;
    rst = 1'b1;
    clear_mon();
    // Bits while IDLE must be ignored.
    for (int i = 0; i < 4; i++) drive_bit(1'b1, (i == 3), 0);
    @(negedge clk);
    n_checks++;
    if (bus.bit_count !== 12'd0 || bus.busy !== 1'b0 || dv_count != 0)
      $display("FAIL idle_ignore: got cnt=%0d busy=%b dv=%0d, want 0/0/0",
               bus.bit_count, bus.busy, dv_count);
    else n_pass++;
  endtask

  task automatic test_good_frame();
    logic lat;
    clear_mon();
    drive_frame(msg, 72, 16'hFEE8, 16, 0, lat);
    repeat (2) @(negedge clk);
    n_checks++;
    if (lat !== 1'b1) $display("FAIL t1_done_latency: got done=%b want 1", lat); else n_pass++;
    n_checks++;
    if (done_count != 1) $display("FAIL t1_done_pulses: got %0d want 1", done_count); else n_pass++;
    n_checks++;
    if ({bus.crc_ok, bus.crc_err} !== 2'b10)
      $display("FAIL t1_result: got ok=%b err=%b want ok=1 err=0", bus.crc_ok, bus.crc_err);
    else n_pass++;
    n_checks++;
    if (bus.rx_crc !== 16'hFEE8) $display("FAIL t1_rx_crc: got %h want fee8", bus.rx_crc); else n_pass++;
    n_checks++;
    if (bus.bit_count !== 12'd72) $display("FAIL t1_bit_count: got %0d want 72", bus.bit_count); else n_pass++;
    n_checks++;
    if (dv_count != 72) $display("FAIL t1_dv_pulses: got %0d want 72", dv_count); else n_pass++;
    n_checks++;
    if (rx_bits !== msg) $display("FAIL t1_payload: got %h want %h", rx_bits, msg); else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL t1_busy_after: got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_bad_frame();
    logic        lat;
    logic [71:0] p2;
    p2     = msg;
    p2[66] = ~p2[66];
    clear_mon();
    drive_frame(p2, 72, 16'hFEE8, 16, 0, lat);
    @(negedge clk);
    n_checks++;
    if (lat !== 1'b1) $display("FAIL t2_done_latency: got done=%b want 1", lat); else n_pass++;
    n_checks++;
    if ({bus.crc_ok, bus.crc_err} !== 2'b01)
      $display("FAIL t2_result: got ok=%b err=%b want ok=0 err=1", bus.crc_ok, bus.crc_err);
    else n_pass++;
    n_checks++;
    if (bus.rx_crc !== 16'hFEE8) $display("FAIL t2_rx_crc: got %h want fee8", bus.rx_crc); else n_pass++;
  endtask

  task automatic test_one_bit();
    logic        lat;
    logic [71:0] p3;
    p3     = '0;
    p3[71] = 1'b1;
    clear_mon();
    drive_frame(p3, 1, 16'h8005, 16, 0, lat);
    @(negedge clk);
    n_checks++;
    if (lat !== 1'b1 || done_count != 1)
      $display("FAIL t3_done: got lat=%b pulses=%0d want 1/1", lat, done_count);
    else n_pass++;
    n_checks++;
    if ({bus.crc_ok, bus.crc_err} !== 2'b10 || bus.rx_crc !== 16'h8005)
      $display("FAIL t3_result: got ok=%b err=%b rx_crc=%h want 1/0/8005",
               bus.crc_ok, bus.crc_err, bus.rx_crc);
    else n_pass++;
    n_checks++;
    if (bus.bit_count !== 12'd1 || dv_count != 1 || rx_bits[71] !== 1'b1)
      $display("FAIL t3_payload: got cnt=%0d dv=%0d bit=%b want 1/1/1",
               bus.bit_count, dv_count, rx_bits[71]);
    else n_pass++;
  endtask

  task automatic test_gaps();
    logic lat;
    clear_mon();
    drive_frame(msg, 72, 16'hFEE8, 16, 30, lat);
    repeat (2) @(negedge clk);
    n_checks++;
    if (lat !== 1'b1 || done_count != 1)
      $display("FAIL t4_done: got lat=%b pulses=%0d want 1/1", lat, done_count);
    else n_pass++;
    n_checks++;
    if ({bus.crc_ok, bus.crc_err} !== 2'b10 || bus.rx_crc !== 16'hFEE8 || bus.bit_count !== 12'd72)
      $display("FAIL t4_result: got ok=%b err=%b rx_crc=%h cnt=%0d want 1/0/fee8/72",
               bus.crc_ok, bus.crc_err, bus.rx_crc, bus.bit_count);
    else n_pass++;
    n_checks++;
    if (dv_count != 72 || rx_bits !== msg)
      $display("FAIL t4_payload: got dv=%0d bits=%h want 72/%h", dv_count, rx_bits, msg);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic        lat;
    logic [71:0] p3;
    p3     = '0;
    p3[71] = 1'b1;
    clear_mon();
    drive_frame(msg, 72, 16'hFEE8, 8, 0, lat);
    n_checks++;
    if (bus.busy !== 1'b1 || done_count != 0)
      $display("FAIL t5_mid_check: got busy=%b pulses=%0d want 1/0", bus.busy, done_count);
    else n_pass++;
    drive_frame(p3, 1, 16'h8005, 16, 0, lat);
    repeat (2) @(negedge clk);
    n_checks++;
    if (done_count != 1) $display("FAIL t5_done_pulses: got %0d want 1", done_count); else n_pass++;
    n_checks++;
    if ({bus.crc_ok, bus.crc_err} !== 2'b10 || bus.bit_count !== 12'd1)
      $display("FAIL t5_result: got ok=%b err=%b cnt=%0d want 1/0/1",
               bus.crc_ok, bus.crc_err, bus.bit_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid_data();
    do_start();
    for (int i = 0; i < 20; i++) drive_bit(msg[71-i], 1'b0, 0);
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.data_valid !== 1'b1 || bus.bit_count !== 12'd20)
      $display("FAIL t6_pre_reset: got busy=%b dv=%b cnt=%0d want 1/1/20",
               bus.busy, bus.data_valid, bus.bit_count);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.data_valid, bus.data_out, bus.done, bus.crc_ok, bus.crc_err,
         bus.rx_crc, bus.bit_count} !== 34'd0)
      $display("FAIL t6_async_reset: got busy=%b dv=%b cnt=%0d rx_crc=%h, want all 0",
               bus.busy, bus.data_valid, bus.bit_count, bus.rx_crc);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    clear_mon();
    for (int i = 0; i < 10; i++) drive_bit(1'b1, (i == 9), 0);
    @(negedge clk);
    n_checks++;
    if (bus.bit_count !== 12'd0 || bus.busy !== 1'b0 || dv_count != 0 || done_count != 0)
      $display("FAIL t6_after_reset: got cnt=%0d busy=%b dv=%0d done=%0d want 0/0/0/0",
               bus.bit_count, bus.busy, dv_count, done_count);
    else n_pass++;
  endtask

  // 16 zero payload bits overflow a 4-bit counter; the all-zero CRC is
  // otherwise correct, so only the overflow can make the frame fail.
  task automatic test_overflow();
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus4.bit_valid = 1'b1;
      bus4.bit_in    = 1'b0;
      bus4.last_data = (i == 15);
      @(negedge clk);
    end
    bus4.bit_valid = 1'b0;
    bus4.last_data = 1'b0;
    n_checks++;
    if (bus4.done !== 1'b1) $display("FAIL ovf_done: got %b want 1", bus4.done); else n_pass++;
    n_checks++;
    if ({bus4.crc_ok, bus4.crc_err} !== 2'b01)
      $display("FAIL ovf_result: got ok=%b err=%b want ok=0 err=1", bus4.crc_ok, bus4.crc_err);
    else n_pass++;
    n_checks++;
    if (bus4.bit_count !== 4'd15) $display("FAIL ovf_bit_count: got %0d want 15", bus4.bit_count);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    msg = "123456789";
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_one_bit();
    test_gaps();
    test_abort();
    test_reset_mid_data();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
